// File: rtl/div_pkg.sv
// Shared encodings and constants for the iterative RV32M divide/remainder unit.
// Op codes match funct3[1:0] so the decoder can pass them straight through.
package div_pkg;

    localparam int DIV_XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CALC    = 2'b01,
        FIXUP   = 2'b10,
        SPECIAL = 2'b11
    } state_t;

    localparam logic [DIV_XLEN-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [DIV_XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

    function automatic logic op_is_signed(input op_t o);
        return (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic op_is_rem(input op_t o);
        return (o == OP_REM) || (o == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not go negative.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // One extra bit so a full 32-bit unsigned divisor still compares correctly.
    assign shifted = {rem, quo[XLEN-1]};
    assign trial   = shifted - {1'b0, divisor};

    // A negative trial implies shifted < divisor, so the restored value fits XLEN bits.
    assign rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];

    generate
        for (genvar gi = 1; gi < XLEN; gi++) begin : g_quo_shift
            assign quo_next[gi] = quo[gi-1];
        end
    endgenerate

    assign quo_next[0] = ~trial[XLEN];

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: magnitudes are divided one bit per clock,
// signs are applied in a final fixup cycle, RISC-V special cases bypass the loop.
module iterative_divider
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    state_t          state_reg;
    state_t          state_next;
    op_t             op_reg;
    logic [CW-1:0]   count_reg;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] quo_reg;
    logic [XLEN-1:0] dvs_reg;
    logic [XLEN-1:0] result_reg;
    logic            neg_quo_reg;
    logic            neg_rem_reg;
    logic            done_reg;

    // Decode of the incoming request
    op_t             op_in;
    logic            in_signed;
    logic            in_rem;
    logic            dvd_neg;
    logic            dvs_neg;
    logic [XLEN-1:0] dvd_abs;
    logic [XLEN-1:0] dvs_abs;
    logic            div_zero;
    logic            overflow;
    logic            special_in;
    logic [XLEN-1:0] special_val;

    // FSM control strobes
    logic            accept;
    logic            step_en;
    logic            fixup_en;
    logic            special_en;

    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] fix_val;

    always_comb begin
        op_in      = op_t'(op);
        in_signed  = op_is_signed(op_in);
        in_rem     = op_is_rem(op_in);
        dvd_neg    = in_signed & dividend[XLEN-1];
        dvs_neg    = in_signed & divisor[XLEN-1];
        dvd_abs    = dvd_neg ? -dividend : dividend;
        dvs_abs    = dvs_neg ? -divisor : divisor;
        div_zero   = (divisor == '0);
        overflow   = in_signed && (dividend == INT_MIN) && (divisor == ALL_ONES);
        special_in = div_zero | overflow;
        // Divide-by-zero takes priority; overflow only matters for a non-zero divisor.
        if (div_zero) begin
            special_val = in_rem ? dividend : ALL_ONES;
        end else begin
            special_val = in_rem ? '0 : INT_MIN;
        end
    end

    div_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem      (rem_reg),
        .quo      (quo_reg),
        .divisor  (dvs_reg),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_comb begin
        if (op_is_rem(op_reg)) begin
            fix_val = neg_rem_reg ? -rem_reg : rem_reg;
        end else begin
            fix_val = neg_quo_reg ? -quo_reg : quo_reg;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    state_next = special_in ? SPECIAL : CALC;
                end
            end
            CALC: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (count_reg == CW'(XLEN - 1)) begin
                    state_next = FIXUP;
                end
            end
            FIXUP:   state_next = IDLE;
            SPECIAL: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy       = (state_reg != IDLE);
        accept     = (state_reg == IDLE) && start && !abort;
        step_en    = (state_reg == CALC) && !abort;
        fixup_en   = (state_reg == FIXUP) && !abort;
        special_en = (state_reg == SPECIAL) && !abort;
    end

    // Datapath; the special-case answer is parked in rem_reg until the SPECIAL cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg      <= OP_DIV;
            count_reg   <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            result_reg  <= '0;
            neg_quo_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                op_reg      <= op_in;
                count_reg   <= '0;
                dvs_reg     <= dvs_abs;
                neg_quo_reg <= dvd_neg ^ dvs_neg;
                neg_rem_reg <= dvd_neg;
                if (special_in) begin
                    rem_reg <= special_val;
                    quo_reg <= '0;
                end else begin
                    rem_reg <= '0;
                    quo_reg <= dvd_abs;
                end
            end
            if (step_en) begin
                rem_reg   <= rem_step;
                quo_reg   <= quo_step;
                count_reg <= count_reg + CW'(1);
            end
            if (fixup_en) begin
                result_reg <= fix_val;
                done_reg   <= 1'b1;
            end
            if (special_en) begin
                result_reg <= rem_reg;
                done_reg   <= 1'b1;
            end
        end
    end

    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Multi-cycle 32-bit integer divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions.
- It is the inverse-direction counterpart of the DSP adder: repeated subtract-and-shift (restoring division), one quotient bit per clock.
- Sits beside the ALU in the execute stage. The core stalls on `busy` and captures `result` on `done`.

Parameters:
- XLEN, 32, operand and result width; also the number of iteration cycles.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when idle.
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (equals funct3[1:0]).
- dividend  input  XLEN  rs1 value; sampled with start.
- divisor  input  XLEN  rs2 value; sampled with start.
- abort  input  1  pipeline flush; cancels any operation in progress.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse; result valid in this cycle.
- result  output  XLEN  quotient or remainder; held until the next done.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, all internal registers cleared. If reset asserts mid-operation, the operation is lost and no done is produced.
- States:
  - IDLE. start=1 latches op, dividend and divisor. Special cases go to SPECIAL; otherwise go to CALC with count=0.
  - CALC. Runs XLEN cycles. Each cycle:
    - shift {rem, quo} left by 1, shifting in the quotient MSB;
    - trial = rem_shifted - |divisor| (XLEN+1 bits);
    - if trial is non-negative, rem=trial and the quotient bit is 1.
    - After count=XLEN-1, go to FIXUP.
  - FIXUP. Applies signs and selects the output, then goes to IDLE. result is registered and done=1 on the following cycle.
    - DIV: quotient negated if the dividend and divisor signs differ.
    - REM: remainder takes the sign of the dividend.
  - SPECIAL. One cycle; result is written and done pulses, then go to IDLE.
- Signed ops (DIV, REM) take absolute values at latch time. Unsigned ops use the operands as-is.
- Latency: for a start accepted at edge t0, done is high in cycle t0+XLEN+2 (34 for XLEN=32). SPECIAL cases give done at t0+2.
- Special cases (RISC-V mandated):
  - Divisor = 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - DIV/REM with dividend = 0x80000000 and divisor = 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- busy=1 in CALC, FIXUP and SPECIAL; busy=0 in IDLE, including the done cycle.
- start while busy is ignored, with no queueing. start in the same cycle as done is accepted, because the FSM is already in IDLE.
- abort:
  - In any non-IDLE state, the next edge returns the FSM to IDLE with busy=0; no done is produced and result is unchanged.
  - abort together with start in IDLE: abort wins and the request is dropped.
- result changes only in a done cycle.

Decomposition:
- Package div_pkg holds:
  - op encodings OP_DIV, OP_DIVU, OP_REM, OP_REMU;
  - state enum IDLE, CALC, FIXUP, SPECIAL;
  - constants INT_MIN = 0x80000000 and ALL_ONES.
- Sub-module div_step is the natural split: combinational, one restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - It is unit-testable in isolation and can later be instantiated twice for radix-4.

Test Plan:
- DIVU 100 / 7 -> done at cycle 34 after start, result=14; REMU 100 / 7 -> result=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -7 / 2 -> 0xFFFFFFFF (-1); REM 7 / -2 -> 1.
- DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; both give done 2 cycles after start.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; done at start+2.
- abort at CALC cycle 10 -> busy drops next cycle, no done, result keeps its prior value. A start pulse at CALC cycle 5 is ignored: only one done is seen.
- rst_n low during CALC -> busy=0, done=0, result=0 immediately (asynchronous). A new DIVU 9 / 3 after release -> 3.
